// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder backed by a bank of byte-writable 32-bit registers.
// In-range accesses return OKAY, out-of-range accesses return SLVERR.
module axi_lite_slave_regs #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 4
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [ADDR_WIDTH-1:0]        awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [DATA_WIDTH/8-1:0]      wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_WIDTH-1:0]        araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                    aw_full_reg;
   logic [ADDR_WIDTH-1:0]   aw_addr_reg;
   logic                    w_full_reg;
   logic [DATA_WIDTH-1:0]   w_data_reg;
   logic [NUM_LANES-1:0]    w_strb_reg;

   logic                    aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [NUM_LANES-1:0]    wr_strb;
   logic                    wr_in_range, rd_in_range;
   logic [IDX_W-1:0]        wr_idx, rd_idx;

   // Readies depend only on state (and reset), never on the valids.
   assign awready = !areset && !aw_full_reg && !bvalid;
   assign wready  = !areset && !w_full_reg && !bvalid;
   assign arready = !areset && !rvalid;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;

   // A held entry takes priority; otherwise use the channel handshaking now.
   assign wr_addr = aw_full_reg ? aw_addr_reg : awaddr;
   assign wr_data = w_full_reg  ? w_data_reg  : wdata;
   assign wr_strb = w_full_reg  ? w_strb_reg  : wstrb;
   assign commit  = (aw_full_reg || aw_hs) && (w_full_reg || w_hs);

   assign wr_in_range = wr_addr < ADDR_LIMIT;
   assign rd_in_range = araddr < ADDR_LIMIT;
   assign wr_idx      = wr_addr[IDX_W+1:2];
   assign rd_idx      = araddr[IDX_W+1:2];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_WIDTH-1:0] value_reg;

         always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
               value_reg <= '0;
            end else if (commit && wr_in_range && (wr_idx == IDX_W'(gi))) begin
               for (int k = 0; k < NUM_LANES; k++) begin
                  if (wr_strb[k]) begin
                     value_reg[8*k +: 8] <= wr_data[8*k +: 8];
                  end
               end
            end
         end

         assign regs_o[DATA_WIDTH*gi +: DATA_WIDTH] = value_reg;
      end
   endgenerate

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         aw_full_reg <= 1'b0;
         aw_addr_reg <= '0;
         w_full_reg  <= 1'b0;
         w_data_reg  <= '0;
         w_strb_reg  <= '0;
         bvalid      <= 1'b0;
         bresp       <= RESP_OKAY;
      end else begin
         if (commit) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            bvalid      <= 1'b1;
            bresp       <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (aw_hs) begin
               aw_full_reg <= 1'b1;
               aw_addr_reg <= awaddr;
            end
            if (w_hs) begin
               w_full_reg <= 1'b1;
               w_data_reg <= wdata;
               w_strb_reg <= wstrb;
            end
         end
         // Commit cannot coincide with a pending response: readies are low then.
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
         end
      end
   end

   // The read samples register state before any same-edge commit lands.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= rd_in_range ? regs_o[DATA_WIDTH*rd_idx +: DATA_WIDTH] : '0;
         rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
         rresp  <= RESP_OKAY;
      end
   end

endmodule
